// File: rtl/xc_malu_issue.sv
// xc_malu_issue -- issue/retire sequencer in front of the xc_malu.
//
// Accepts one decoded multi-cycle op, holds it stable to the MALU until
// malu_ready, captures the 64-bit result and returns it to the register
// file as one (narrow) or two (wide) 32-bit write-backs.
//
// Ports:
//   clock, resetn (sync, active low), flush (pipeline abort)
//   req_*   : op request (valid/ready), one-hot uop and pack width,
//             operands, destination rd, wide flag
//   malu_*  : MALU request side; malu_flush strobes MALU state clear
//   wb_*    : register-file write-back (valid/ready)
//   busy    : sequencer not idle
//   timeout : sticky watchdog flag
//
// Build option: XC_MALU_ISSUE_TIMEOUT_EN enables the RUN-state watchdog
// (TIMEOUT cycles without malu_ready). Without it timeout is tied 0 and
// RUN waits indefinitely for malu_ready.
module xc_malu_issue #(
  parameter int TIMEOUT = 63
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [13:0] req_uop,
  input  logic [4:0]  req_pw,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [4:0]  req_rd,
  input  logic        req_wide,
  output logic        malu_valid,
  output logic        malu_flush,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  input  logic [63:0] malu_result,
  input  logic        malu_ready,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, RUN, WB_LO, WB_HI} state_t;

  state_t      state, state_nx;
  logic [13:0] uop_q;
  logic [4:0]  pw_q;
  logic [31:0] rs1_q, rs2_q, rs3_q;
  logic [4:0]  rd_q;
  logic        wide_q;
  logic [63:0] res_q;
  logic        rst_d;    // high for the first cycle out of reset
  logic        accept;
  logic        to_hit;   // watchdog expiry in the current RUN cycle

  // A zero uop is not an op; flush also blocks acceptance.
  assign accept = (state == IDLE) && req_valid && (|req_uop) && !flush;

`ifdef XC_MALU_ISSUE_TIMEOUT_EN
  localparam int CLOG = $clog2(TIMEOUT + 1);
  localparam int CW   = (CLOG < 6) ? 6 : ((CLOG > 16) ? 16 : CLOG);

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  // cnt_q counts completed RUN cycles without malu_ready, so the
  // TIMEOUT-th waiting cycle sees cnt_q == TIMEOUT-1.
  assign to_hit  = (state == RUN) && !malu_ready && (cnt_q == CW'(TIMEOUT - 1));
  assign timeout = timeout_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept)
        cnt_q <= '0;
      else if (state == RUN && !malu_ready)
        cnt_q <= cnt_q + 1'b1;
      if (to_hit && !flush)
        timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)                  state_nx = RUN;
      RUN:     if (malu_ready || to_hit)    state_nx = WB_LO;
      WB_LO:   if (wb_ready)                state_nx = wide_q ? WB_HI : IDLE;
      WB_HI:   if (wb_ready)                state_nx = IDLE;
      default:                              state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      uop_q  <= '0;
      pw_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rs3_q  <= '0;
      rd_q   <= '0;
      wide_q <= 1'b0;
      res_q  <= '0;
      rst_d  <= 1'b1;
    end else begin
      state <= state_nx;
      rst_d <= 1'b0;
      if (accept) begin
        uop_q  <= req_uop;
        pw_q   <= req_pw;
        rs1_q  <= req_rs1;
        rs2_q  <= req_rs2;
        rs3_q  <= req_rs3;
        rd_q   <= req_rd;
        wide_q <= req_wide;
      end
      // An expired watchdog retires the op with a zero result.
      if (state == RUN && !flush) begin
        if (malu_ready)  res_q <= malu_result;
        else if (to_hit) res_q <= '0;
      end
    end
  end

  assign req_ready  = (state == IDLE) && !flush;
  assign malu_valid = (state == RUN);
  assign malu_uop   = malu_valid ? uop_q : '0;
  assign malu_pw    = pw_q;
  assign malu_rs1   = rs1_q;
  assign malu_rs2   = rs2_q;
  assign malu_rs3   = rs3_q;
  // resetn gates the post-reset pulse so it never shows while still in reset.
  assign malu_flush = (rst_d && resetn) || ((state == RUN) && (flush || to_hit));

  assign wb_valid = (state == WB_LO) || (state == WB_HI);
  assign wb_rd    = (state == WB_LO) ? rd_q :
                    (state == WB_HI) ? (rd_q | 5'd1) : '0;
  assign wb_data  = (state == WB_LO) ? res_q[31:0] :
                    (state == WB_HI) ? res_q[63:32] : '0;
  assign busy     = (state != IDLE);

endmodule
